// File: rtl/pc_counter.sv
// -----------------------------------------------------------------------------
// pc_counter
//
// Program counter register stage. Holds the current instruction address and
// updates it once per rising Clock edge by increment, absolute load or signed
// relative branch. An absolute load also captures a link (return) address.
// All state sits on one full-scan chain:
//   SDI -> PC[0] .. PC[WIDTH-1] -> LinkAddr[0] .. LinkAddr[WIDTH-1] -> Wrap -> SDO
//
// Priority per edge: Test > Load > Branch > Inc > hold.
// Requests are level-sampled every edge; there is no handshake, and a request
// that loses on priority is dropped rather than queued.
//
// Parameters
//   WIDTH         address width in bits (4..32)
//   OFFSET_WIDTH  width of the two's-complement branch offset (2..WIDTH)
//   RESET_VALUE   PC value forced by reset
//
// Ports
//   Clock      in   rising-edge clock
//   nReset     in   asynchronous active-low reset
//   Test       in   scan enable, 1 = shift
//   SDI        in   scan data in
//   SDO        out  scan data out (always the Wrap register)
//   Inc        in   increment request
//   Load       in   absolute load request
//   LoadValue  in   absolute target address   [WIDTH]
//   Branch     in   relative branch request
//   Offset     in   signed branch offset      [OFFSET_WIDTH]
//   PC         out  current address (registered)          [WIDTH]
//   LinkAddr   out  return address captured on Load (reg.) [WIDTH]
//   Wrap       out  one-cycle pulse: an increment went all-ones -> zero
// -----------------------------------------------------------------------------
module pc_counter #(
    parameter int                 WIDTH        = 16,
    parameter int                 OFFSET_WIDTH = 8,
    parameter logic [WIDTH-1:0]   RESET_VALUE  = '0
) (
    input  logic                    Clock,
    input  logic                    nReset,
    input  logic                    Test,
    input  logic                    SDI,
    output logic                    SDO,
    input  logic                    Inc,
    input  logic                    Load,
    input  logic [WIDTH-1:0]        LoadValue,
    input  logic                    Branch,
    input  logic [OFFSET_WIDTH-1:0] Offset,
    output logic [WIDTH-1:0]        PC,
    output logic [WIDTH-1:0]        LinkAddr,
    output logic                    Wrap
);

    logic [WIDTH-1:0] pc_q,   pc_d;
    logic [WIDTH-1:0] link_q, link_d;
    logic             wrap_q, wrap_d;

    logic [WIDTH-1:0] pc_plus_one;
    logic [WIDTH-1:0] offset_ext;

    assign pc_plus_one = pc_q + WIDTH'(1);

    // Size-casting a signed value sign-extends it; this also covers
    // OFFSET_WIDTH == WIDTH without a zero-width replication.
    assign offset_ext  = WIDTH'($signed(Offset));

    always_comb begin
        pc_d   = pc_q;
        link_d = link_q;
        wrap_d = 1'b0;              // Wrap is a pulse: cleared unless an increment wraps
        if (Test) begin
            // One place per edge along the chain, functional inputs ignored.
            pc_d   = {pc_q[WIDTH-2:0], SDI};
            link_d = {link_q[WIDTH-2:0], pc_q[WIDTH-1]};
            wrap_d = link_q[WIDTH-1];
        end else if (Load) begin
            pc_d   = LoadValue;
            link_d = pc_plus_one;   // return address from the pre-edge PC
        end else if (Branch) begin
            // Modular add; overflow/underflow wraps silently and never flags Wrap.
            pc_d   = pc_q + offset_ext;
        end else if (Inc) begin
            pc_d   = pc_plus_one;
            wrap_d = &pc_q;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            pc_q   <= RESET_VALUE;
            link_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            link_q <= link_d;
            wrap_q <= wrap_d;
        end
    end

    assign PC       = pc_q;
    assign LinkAddr = link_q;
    assign Wrap     = wrap_q;
    assign SDO      = wrap_q;

endmodule

// File: tb/tb_pc_counter.sv
// -----------------------------------------------------------------------------
// tb_pc_counter
//
// Directed scenarios followed by randomized traffic, all compared against a
// behavioural model of the program counter kept as plain integers and a bit
// array for the scan chain.
// -----------------------------------------------------------------------------
module tb_pc_counter;

    localparam int          W    = 16;
    localparam int          OW   = 8;
    localparam int unsigned MASK = 32'h0000_FFFF;
    localparam int          CHN  = 2 * W + 1;

    // ---------------- clock / reset ----------------
    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic          nReset;
    logic          Test;
    logic          SDI;
    logic          SDO;
    logic          Inc;
    logic          Load;
    logic [W-1:0]  LoadValue;
    logic          Branch;
    logic [OW-1:0] Offset;
    logic [W-1:0]  PC;
    logic [W-1:0]  LinkAddr;
    logic          Wrap;

    pc_counter #(
        .WIDTH        (W),
        .OFFSET_WIDTH (OW),
        .RESET_VALUE  (16'h0000)
    ) dut (
        .Clock     (Clock),
        .nReset    (nReset),
        .Test      (Test),
        .SDI       (SDI),
        .SDO       (SDO),
        .Inc       (Inc),
        .Load      (Load),
        .LoadValue (LoadValue),
        .Branch    (Branch),
        .Offset    (Offset),
        .PC        (PC),
        .LinkAddr  (LinkAddr),
        .Wrap      (Wrap)
    );

    // ---------------- reference model ----------------
    int unsigned m_pc;
    int unsigned m_link;
    logic        m_wrap;

    int checks = 0;
    int errors = 0;

    task automatic model_reset();
        m_pc   = 0;
        m_link = 0;
        m_wrap = 1'b0;
    endtask

    task automatic model_step(input logic t, input logic sdi, input logic ld,
                              input logic [W-1:0] lv, input logic br,
                              input logic [OW-1:0] off, input logic inc);
        logic chain [CHN];
        int   so;
        if (t) begin
            // Flatten state into chain positions, shift by one, unflatten.
            for (int i = 0; i < W; i++) begin
                chain[i]     = m_pc[i];
                chain[W + i] = m_link[i];
            end
            chain[2*W] = m_wrap;
            for (int i = CHN - 1; i > 0; i--) chain[i] = chain[i-1];
            chain[0] = sdi;
            m_pc   = 0;
            m_link = 0;
            for (int i = 0; i < W; i++) begin
                m_pc[i]   = chain[i];
                m_link[i] = chain[W + i];
            end
            m_wrap = chain[2*W];
        end else if (ld) begin
            m_link = (m_pc + 1) & MASK;
            m_pc   = 32'(lv);
            m_wrap = 1'b0;
        end else if (br) begin
            so     = off[OW-1] ? int'(off) - (1 << OW) : int'(off);
            m_pc   = int'(m_pc + so) & MASK;
            m_wrap = 1'b0;
        end else if (inc) begin
            m_wrap = (m_pc == MASK);
            m_pc   = (m_pc + 1) & MASK;
        end else begin
            m_wrap = 1'b0;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},   32'(PC),       m_pc);
        check({tag, ".link"}, 32'(LinkAddr), m_link);
        check({tag, ".wrap"}, 32'(Wrap),     32'(m_wrap));
        check({tag, ".sdo"},  32'(SDO),      32'(m_wrap));
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_edge(input string tag, input logic t, input logic sdi, input logic ld,
                           input logic [W-1:0] lv, input logic br,
                           input logic [OW-1:0] off, input logic inc);
        Test = t; SDI = sdi; Load = ld; LoadValue = lv;
        Branch = br; Offset = off; Inc = inc;
        model_step(t, sdi, ld, lv, br, off, inc);
        @(posedge Clock);
        #1;
        check_all(tag);
    endtask

    task automatic do_load(input string tag, input logic [W-1:0] v);
        do_edge(tag, 1'b0, 1'b0, 1'b1, v, 1'b0, '0, 1'b0);
    endtask

    task automatic do_inc(input string tag);
        do_edge(tag, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    endtask

    task automatic do_branch(input string tag, input logic [OW-1:0] off);
        do_edge(tag, 1'b0, 1'b0, 1'b0, '0, 1'b1, off, 1'b0);
    endtask

    task automatic do_shift(input string tag, input logic b);
        do_edge(tag, 1'b1, b, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    // Reset asserted mid-cycle; outputs must clear with no clock edge.
    task automatic pulse_reset(input string tag);
        @(negedge Clock);
        nReset = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        @(negedge Clock);
        nReset = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    logic       exp_q [$];
    logic       pat [CHN];
    logic [W-1:0] lv_r;

    initial begin
        nReset = 1'b0; Test = 1'b0; SDI = 1'b0; Inc = 1'b0; Load = 1'b0;
        LoadValue = '0; Branch = 1'b0; Offset = '0;
        model_reset();
        #2;
        check_all("por");
        @(negedge Clock);
        nReset = 1'b1;

        // Reset from random state, then first edge after release increments.
        do_load("rs_ld", 16'(($urandom & MASK)));
        do_branch("rs_br", 8'($urandom_range(0, 255)));
        pulse_reset("rst_mid");
        check("rst_pc_const", 32'(PC), 32'h0);
        do_inc("rst_inc");
        check("rst_inc_pc1", 32'(PC), 32'h1);

        // Increment across all-ones with a single Wrap pulse.
        do_load("wr_ld", 16'hFFFE);
        do_inc("wr_i1");
        check("wr_i1_pc", 32'(PC), 32'hFFFF);
        check("wr_i1_w",  32'(Wrap), 32'h0);
        do_inc("wr_i2");
        check("wr_i2_pc", 32'(PC), 32'h0000);
        check("wr_i2_w",  32'(Wrap), 32'h1);
        do_inc("wr_i3");
        check("wr_i3_pc", 32'(PC), 32'h0001);
        check("wr_i3_w",  32'(Wrap), 32'h0);

        // Signed branches including full negative offset.
        do_load("br_ld", 16'h0010);
        do_branch("br_neg", 8'h80);
        check("br_neg_pc", 32'(PC), 32'hFF90);
        check("br_neg_w",  32'(Wrap), 32'h0);
        do_branch("br_pos", 8'h7F);
        check("br_pos_pc", 32'(PC), 32'h000F);
        // Branch past all-ones wraps silently.
        do_load("br_ld2", 16'hFFFF);
        do_branch("br_ovf", 8'h01);
        check("br_ovf_pc", 32'(PC), 32'h0000);
        check("br_ovf_w",  32'(Wrap), 32'h0);

        // Priority Load > Branch > Inc.
        do_load("pr_ld", 16'h1234);
        do_edge("pr_all", 1'b0, 1'b0, 1'b1, 16'h4000, 1'b1, 8'h05, 1'b1);
        check("pr_all_pc",   32'(PC), 32'h4000);
        check("pr_all_link", 32'(LinkAddr), 32'h1235);
        do_edge("pr_bi", 1'b0, 1'b0, 1'b0, 16'h7777, 1'b1, 8'h02, 1'b1);
        check("pr_bi_pc", 32'(PC), 32'h4002);

        // Scan: shift out existing state, then the shifted-in pattern emerges.
        do_load("sc_ld0", 16'h0FFF);
        do_load("sc_ld", 16'hA5A5);
        exp_q.delete();
        exp_q.push_back(m_wrap);
        for (int i = W - 1; i >= 0; i--) exp_q.push_back(m_link[i]);
        for (int i = W - 1; i >= 0; i--) exp_q.push_back(m_pc[i]);
        for (int k = 0; k < CHN; k++) pat[k] = 1'($urandom_range(0, 1));
        for (int k = 0; k < CHN; k++) begin
            check($sformatf("sc_out%0d", k), 32'(SDO), 32'(exp_q.pop_front()));
            do_shift("sc_in", pat[k]);
        end
        for (int k = 0; k < CHN; k++) begin
            check($sformatf("sc_pat%0d", k), 32'(SDO), 32'(pat[k]));
            do_shift("sc_flush", 1'($urandom_range(0, 1)));
        end
        do_inc("sc_resume1");
        do_inc("sc_resume2");

        // Reset mid-scan discards partial contents.
        for (int k = 0; k < 5; k++) do_shift("ms_sh", 1'b1);
        pulse_reset("ms_rst");
        do_inc("ms_inc");

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 63) == 0) begin
                pulse_reset("rnd_rst");
            end else begin
                lv_r = ($urandom_range(0, 3) == 0) ? (16'hFFF0 | 16'($urandom_range(0, 15)))
                                                   : 16'($urandom & MASK);
                do_edge("rnd",
                        1'($urandom_range(0, 7) == 0),
                        1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 5) == 0),
                        lv_r,
                        1'($urandom_range(0, 2) == 0),
                        8'($urandom_range(0, 255)),
                        1'($urandom_range(0, 3) != 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
